// File: rtl/conv_window_3x3_if.sv
// Stream interface for conv_window_3x3: raster pixel input with ready, and
// unthrottled window/coordinate output beats.
interface conv_window_3x3_if #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int BITW   = 8
) ();
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                 in_valid;
  logic                 in_ready;
  logic [BITW-1:0]      in_pixel;
  logic                 out_valid;
  logic [9*BITW-1:0]    out_win;
  logic [XW-1:0]        out_x;
  logic [YW-1:0]        out_y;
  logic                 out_border;
  logic                 out_last;

  modport master (
    output in_valid, in_pixel,
    input  in_ready, out_valid, out_win, out_x, out_y, out_border, out_last
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, out_valid, out_win, out_x, out_y, out_border, out_last
  );
endinterface

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// one output beat per pixel position with border centers zeroed.
module conv_window_3x3 #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int BITW   = 8
) (
  input logic              clk,
  input logic              rst_n,
  conv_window_3x3_if.slave io_bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]          r_state;
  logic [XW-1:0]       r_in_x;
  logic [YW-1:0]       r_in_y;
  logic [XW-1:0]       r_cx;
  logic [YW-1:0]       r_cy;
  logic [BITW-1:0]     r_lb1 [WIDTH];
  logic [BITW-1:0]     r_lb2 [WIDTH];
  logic [BITW-1:0]     r_win [3][3];

  logic                r_o_valid;
  logic [9*BITW-1:0]   r_o_win;
  logic [XW-1:0]       r_o_x;
  logic [YW-1:0]       r_o_y;
  logic                r_o_border;
  logic                r_o_last;

  logic                w_acc;
  logic                w_emit;
  logic                w_in_end_x;
  logic                w_in_end;
  logic                w_c_end_x;
  logic                w_c_end;
  logic                w_c_border;
  logic [BITW-1:0]     w_win_nxt [3][3];
  logic [9*BITW-1:0]   w_win_flat;

  assign w_acc      = io_bus.in_valid && (r_state != ST_FLUSH);
  assign w_emit     = (r_state == ST_RUN && w_acc) || (r_state == ST_FLUSH);
  assign w_in_end_x = (r_in_x == X_MAX);
  assign w_in_end   = w_in_end_x && (r_in_y == Y_MAX);
  assign w_c_end_x  = (r_cx == X_MAX);
  assign w_c_end    = w_c_end_x && (r_cy == Y_MAX);
  assign w_c_border = (r_cy == '0) || (r_cy == Y_MAX) || (r_cx == '0) || (r_cx == X_MAX);

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_win_nxt[i][0] = r_win[i][1];
      w_win_nxt[i][1] = r_win[i][2];
    end
    w_win_nxt[0][2] = r_lb2[r_in_x];
    w_win_nxt[1][2] = r_lb1[r_in_x];
    w_win_nxt[2][2] = io_bus.in_pixel;
  end

  // Border masking also hides stale columns carried across a row wrap.
  always_comb begin
    w_win_flat = '0;
    if (!w_c_border) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          w_win_flat[BITW*(3*i+j) +: BITW] = w_win_nxt[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb2[r_in_x] <= r_lb1[r_in_x];
      r_lb1[r_in_x] <= io_bus.in_pixel;
      r_win         <= w_win_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_in_x     <= '0;
      r_in_y     <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_o_valid  <= 1'b0;
      r_o_win    <= '0;
      r_o_x      <= '0;
      r_o_y      <= '0;
      r_o_border <= 1'b0;
      r_o_last   <= 1'b0;
    end else begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;

      if (w_acc) begin
        if (w_in_end_x) begin
          r_in_x <= '0;
          r_in_y <= (r_in_y == Y_MAX) ? '0 : r_in_y + 1'b1;
        end else begin
          r_in_x <= r_in_x + 1'b1;
        end
      end

      if (w_emit) begin
        r_o_valid  <= 1'b1;
        r_o_x      <= r_cx;
        r_o_y      <= r_cy;
        r_o_border <= w_c_border;
        r_o_win    <= w_win_flat;
        r_o_last   <= w_c_end;
        if (w_c_end_x) begin
          r_cx <= '0;
          r_cy <= (r_cy == Y_MAX) ? '0 : r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end

      case (r_state)
        ST_FILL:  if (w_acc && r_in_y == YW'(1) && r_in_x == '0) r_state <= ST_RUN;
        ST_RUN:   if (w_acc && w_in_end) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_c_end) r_state <= ST_FILL;
        default:  r_state <= ST_FILL;
      endcase
    end
  end

  assign io_bus.in_ready   = (r_state != ST_FLUSH);
  assign io_bus.out_valid  = r_o_valid;
  assign io_bus.out_win    = r_o_win;
  assign io_bus.out_x      = r_o_x;
  assign io_bus.out_y      = r_o_y;
  assign io_bus.out_border = r_o_border;
  assign io_bus.out_last   = r_o_last;
endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3: 4x4 frames with exact window checks,
// plus a 256x256 frame scored through a Sobel X stage against a golden image.
module tb_conv_window_3x3;
  localparam int W = 4, H = 4, BW = 8, BIGW = 256, BIGH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_3x3_if #(.WIDTH(W), .HEIGHT(H), .BITW(BW)) bus ();
  conv_window_3x3_if #(.WIDTH(BIGW), .HEIGHT(BIGH), .BITW(BW)) bbus ();

  conv_window_3x3 #(.WIDTH(W), .HEIGHT(H), .BITW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus));
  conv_window_3x3 #(.WIDTH(BIGW), .HEIGHT(BIGH), .BITW(BW)) dut_big (
    .clk(clk), .rst_n(rst_n), .io_bus(bbus));

  typedef struct {
    logic [1:0]      x;
    logic [1:0]      y;
    logic            border;
    logic            last;
    logic [9*BW-1:0] win;
  } beat_t;

  beat_t q[$];
  int    qb[$];
  int    total = 0, bad = 0;
  int    beats = 0, lasts = 0, big_beats = 0;
  int    big_128_96 = -1, big_128_128 = -1;
  logic [9*BW-1:0] cap11, cap22;
  logic  prev_acc = 1'b0, prev_flush = 1'b0;

  function automatic logic [9*BW-1:0] exp_win4(int base, int y, int x);
    logic [9*BW-1:0] w = '0;
    if (y == 0 || y == H-1 || x == 0 || x == W-1) return w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[BW*(3*i+j) +: BW] = 8'(base + (y-1+i)*W + (x-1+j));
    return w;
  endfunction

  function automatic beat_t make_beat(int base, int m);
    beat_t b;
    b.y = 2'(m / W);
    b.x = 2'(m % W);
    b.border = (m / W == 0) || (m / W == H-1) || (m % W == 0) || (m % W == W-1);
    b.last = (m == W*H-1);
    b.win = exp_win4(base, m / W, m % W);
    return b;
  endfunction

  function automatic int sobel_x(int p[3][3]);
    int gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    if (gx < 0) gx = -gx;
    return (gx > 255) ? 255 : gx;
  endfunction

  function automatic int sobel_win(logic [9*BW-1:0] w);
    int p[3][3];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(w[BW*(3*i+j) +: BW]);
    return sobel_x(p);
  endfunction

  function automatic int big_pix(int y, int x);
    return (y >= 96 && y <= 159 && x >= 96 && x <= 159) ? 255 : 0;
  endfunction

  function automatic int big_gold(int y, int x);
    int p[3][3];
    if (y == 0 || y == BIGH-1 || x == 0 || x == BIGW-1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = big_pix(y-1+i, x-1+j);
    return sobel_x(p);
  endfunction

  always @(posedge clk) begin
    prev_acc   <= bus.in_valid & bus.in_ready;
    prev_flush <= !bus.in_ready;
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      beat_t e;
      beats++;
      total++;
      if (!(prev_acc || prev_flush)) begin
        bad++;
        $display("FAIL beat_source: out_valid=1 without prior accept or flush, got x=%0d y=%0d", bus.out_x, bus.out_y);
      end
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got x=%0d y=%0d, required no beat", bus.out_x, bus.out_y);
      end else begin
        e = q.pop_front();
        if ({bus.out_x, bus.out_y, bus.out_border, bus.out_last, bus.out_win} !==
            {e.x, e.y, e.border, e.last, e.win}) begin
          bad++;
          $display("FAIL beat: got x=%0d y=%0d b=%0b l=%0b win=%h, required x=%0d y=%0d b=%0b l=%0b win=%h",
                   bus.out_x, bus.out_y, bus.out_border, bus.out_last, bus.out_win,
                   e.x, e.y, e.border, e.last, e.win);
        end
      end
      if (bus.out_last) lasts++;
      if (bus.out_x == 2'd1 && bus.out_y == 2'd1) cap11 = bus.out_win;
      if (bus.out_x == 2'd2 && bus.out_y == 2'd2) cap22 = bus.out_win;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bbus.out_valid) begin
      int a, e;
      a = sobel_win(bbus.out_win);
      big_beats++;
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL big_unexpected: got beat at y=%0d x=%0d, required none", bbus.out_y, bbus.out_x);
      end else begin
        e = qb.pop_front();
        if (a != e) begin
          bad++;
          $display("FAIL big_sobel y=%0d x=%0d: got %0d, required %0d", bbus.out_y, bbus.out_x, a, e);
        end
      end
      if (bbus.out_y == 8'd128 && bbus.out_x == 8'd96)  big_128_96  = a;
      if (bbus.out_y == 8'd128 && bbus.out_x == 8'd128) big_128_128 = a;
    end
  end

  task automatic push_small(int base, int n);
    if (n >= W+1) q.push_back(make_beat(base, n - (W+1)));
    if (n == W*H-1)
      for (int m = W*H-W-1; m < W*H; m++) q.push_back(make_beat(base, m));
  endtask

  task automatic send_pixel(int base, int n, bit gap);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'(base + n);
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL ready_timeout: in_ready=0 for %0d cycles, required 1", guard);
    end
    push_small(base, n);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((q.size() != 0 || qb.size() != 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d beats still pending, required 0", q.size() + qb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_border, bus.out_last, bus.out_x, bus.out_y, bus.out_win} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%0b win=%h x=%0d y=%0d, required all 0",
               bus.out_valid, bus.out_win, bus.out_x, bus.out_y);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beats = 0; lasts = 0;
    for (int n = 0; n < W+1; n++) send_pixel(0, n, 1'b0);
    @(negedge clk);
    total++;
    if (beats != 0) begin
      bad++;
      $display("FAIL fill_silent: got %0d beats, required 0", beats);
    end
    for (int n = W+1; n < W*H; n++) send_pixel(0, n, 1'b0);
    wait_drain();
    total++;
    if (beats != W*H) begin bad++; $display("FAIL basic_count: got %0d, required %0d", beats, W*H); end
    total++;
    if (lasts != 1) begin bad++; $display("FAIL basic_last: got %0d, required 1", lasts); end
    total++;
    if (cap11 !== {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}) begin
      bad++; $display("FAIL center11: got %h, required 0a0908060504020100", cap11);
    end
    total++;
    if (cap22 !== {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}) begin
      bad++; $display("FAIL center22: got %h, required 0f0e0d0b0a09070605", cap22);
    end
  endtask

  task automatic test_toggle();
    beats = 0; lasts = 0;
    for (int n = 0; n < W*H; n++) send_pixel(0, n, 1'b1);
    wait_drain();
    total++;
    if (beats != W*H || lasts != 1) begin
      bad++; $display("FAIL toggle_count: got beats=%0d lasts=%0d, required %0d/1", beats, lasts, W*H);
    end
  endtask

  task automatic test_flush_hold();
    int low = 0;
    beats = 0;
    for (int n = 0; n < W*H; n++) send_pixel(0, n, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'hAA;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      low++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (low != W+1) begin bad++; $display("FAIL flush_ready_low: got %0d cycles, required %0d", low, W+1); end
    wait_drain();
    cap11 = '1;
    for (int n = 0; n < W*H; n++) send_pixel(0, n, 1'b0);
    wait_drain();
    total++;
    if (beats != 2*W*H) begin bad++; $display("FAIL flush_next_count: got %0d, required %0d", beats, 2*W*H); end
    total++;
    if (cap11 !== {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}) begin
      bad++; $display("FAIL flush_next_center11: got %h, required 0a0908060504020100", cap11);
    end
  endtask

  task automatic test_back_to_back();
    beats = 0; lasts = 0;
    for (int n = 0; n < W*H; n++) send_pixel(0, n, 1'b0);
    for (int n = 0; n < W*H; n++) send_pixel(100, n, 1'b0);
    wait_drain();
    total++;
    if (beats != 2*W*H || lasts != 2) begin
      bad++; $display("FAIL b2b_count: got beats=%0d lasts=%0d, required %0d/2", beats, lasts, 2*W*H);
    end
    total++;
    if (cap11 !== {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100}) begin
      bad++; $display("FAIL b2b_center11: got %h, required 6e6d6c6a6968666564", cap11);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 9; n++) send_pixel(0, n, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %0b, required 1", bus.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_border, bus.out_last, bus.out_x, bus.out_y, bus.out_win} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got valid=%0b x=%0d y=%0d win=%h, required all 0",
                      bus.out_valid, bus.out_x, bus.out_y, bus.out_win);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %0b, required 1", bus.in_ready); end
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats = 0; lasts = 0;
    for (int n = 0; n < W*H; n++) send_pixel(0, n, 1'b0);
    wait_drain();
    total++;
    if (beats != W*H || lasts != 1) begin
      bad++; $display("FAIL mid_refill_count: got beats=%0d lasts=%0d, required %0d/1", beats, lasts, W*H);
    end
  endtask

  task automatic test_big_sobel();
    big_beats = 0;
    for (int n = 0; n < BIGW*BIGH; n++) begin
      if (!bbus.in_ready) begin
        total++; bad++;
        $display("FAIL big_ready: got 0 at n=%0d, required 1", n);
        break;
      end
      bbus.in_valid = 1'b1;
      bbus.in_pixel = 8'(big_pix(n / BIGW, n % BIGW));
      if (n >= BIGW+1) qb.push_back(big_gold((n-BIGW-1) / BIGW, (n-BIGW-1) % BIGW));
      if (n == BIGW*BIGH-1)
        for (int m = BIGW*BIGH-BIGW-1; m < BIGW*BIGH; m++) qb.push_back(big_gold(m / BIGW, m % BIGW));
      @(posedge clk); #1;
    end
    bbus.in_valid = 1'b0;
    wait_drain();
    total++;
    if (big_beats != BIGW*BIGH) begin bad++; $display("FAIL big_count: got %0d, required %0d", big_beats, BIGW*BIGH); end
    total++;
    if (big_128_96 != 255) begin bad++; $display("FAIL big_edge_128_96: got %0d, required 255", big_128_96); end
    total++;
    if (big_128_128 != 0) begin bad++; $display("FAIL big_flat_128_128: got %0d, required 0", big_128_128); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bbus.in_valid = 1'b0;
    bbus.in_pixel = '0;
    test_reset();
    test_basic();
    test_toggle();
    test_flush_hold();
    test_back_to_back();
    test_reset_mid();
    test_big_sobel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
